// File: rtl/sync_fifo_dp_pkg.sv
// sync_fifo_dp_pkg: shared types and helpers for the sync_fifo_dp FIFO.
//   fifo_flags_t : registered status flag bundle
//   FLAGS_RST    : flag values held during reset
//   depth_of     : DEPTH from ADDR_WIDTH
//   byte_parity  : even-parity bit for one data byte
package sync_fifo_dp_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dp_ram_core.sv
// dp_ram_core: simple dual-port RAM, one clock, registered read port with enable.
//   i_clk, i_rst_n       : clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr         : read request; o_rdata updates on the next edge
//   o_rdata              : registered read data, 0 after reset
// Array contents are not reset; they start as all-ones in simulation.
module dp_ram_core #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '1};
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_dp.sv
// sync_fifo_dp: single-clock FIFO on an inferred dual-port RAM with registered read.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_wr_en, i_data     : write request and data
//   i_rd_en             : read request
//   o_q, o_q_valid      : read data (1-cycle latency) and its valid pulse
//   o_full, o_empty     : count == DEPTH / count == 0
//   o_almost_full/empty : count >= AF_LEVEL / count <= AE_LEVEL
//   o_word_count        : occupancy
//   o_overflow/underflow: one-cycle pulse on a rejected write/read
// Optional SYNC_FIFO_DP_PARITY_EN adds per-byte even parity:
//   i_parity_inj        : flips byte-0 parity on write
//   o_parity_err        : pulses with o_q_valid on a parity mismatch
module sync_fifo_dp
    import sync_fifo_dp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int AF_LEVEL   = depth_of(ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_q_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_overflow,
    output logic                  o_underflow
`ifdef SYNC_FIFO_DP_PARITY_EN
    ,
    input  logic                  i_parity_inj,
    output logic                  o_parity_err
`endif
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;
`ifdef SYNC_FIFO_DP_PARITY_EN
    localparam int NB = DATA_WIDTH / 8;
    localparam int RW = DATA_WIDTH + NB;
`else
    localparam int RW = DATA_WIDTH;
`endif

    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
    logic [CW-1:0]         r_count, w_count_nxt;
    fifo_flags_t           r_flags, w_flags_nxt;
    logic                  r_q_valid, r_ovf, r_unf;
    logic                  w_wr_ok, w_rd_ok;
    logic [RW-1:0]         w_wr_word, w_rd_word;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_rd_ok = i_rd_en & ~r_flags.empty;
    assign w_wr_ok = i_wr_en & (~r_flags.full | w_rd_ok);

    always_comb begin
        w_count_nxt = (w_wr_ok && !w_rd_ok) ? r_count + 1'b1 :
                      (w_rd_ok && !w_wr_ok) ? r_count - 1'b1 : r_count;
        w_flags_nxt.full         = w_count_nxt == CW'(DEPTH);
        w_flags_nxt.empty        = w_count_nxt == '0;
        w_flags_nxt.almost_full  = w_count_nxt >= CW'(AF_LEVEL);
        w_flags_nxt.almost_empty = w_count_nxt <= CW'(AE_LEVEL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_flags   <= FLAGS_RST;
            r_q_valid <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
            r_count   <= w_count_nxt;
            r_flags   <= w_flags_nxt;
            r_q_valid <= w_rd_ok;
            r_ovf     <= i_wr_en & ~w_wr_ok;
            r_unf     <= i_rd_en & ~w_rd_ok;
        end
    end

`ifdef SYNC_FIFO_DP_PARITY_EN
    logic [NB-1:0] w_wr_par, w_rd_par;

    always_comb begin
        w_wr_par = '0;
        w_rd_par = '0;
        for (int b = 0; b < NB; b++) begin
            w_wr_par[b] = byte_parity(i_data[8*b +: 8]);
            w_rd_par[b] = byte_parity(w_rd_word[8*b +: 8]);
        end
        w_wr_par[0] = w_wr_par[0] ^ i_parity_inj;
    end

    assign w_wr_word    = {w_wr_par, i_data};
    // Parity bits sit above the data; recompute over the registered word and compare.
    assign o_parity_err = r_q_valid & (w_rd_par != w_rd_word[RW-1:DATA_WIDTH]);
`else
    assign w_wr_word = i_data;
`endif

    dp_ram_core #(
        .WIDTH      (RW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr),
        .i_wdata (w_wr_word),
        .i_re    (w_rd_ok),
        .i_raddr (r_rptr),
        .o_rdata (w_rd_word)
    );

    assign o_q            = w_rd_word[DATA_WIDTH-1:0];
    assign o_q_valid      = r_q_valid;
    assign o_full         = r_flags.full;
    assign o_empty        = r_flags.empty;
    assign o_almost_full  = r_flags.almost_full;
    assign o_almost_empty = r_flags.almost_empty;
    assign o_word_count   = r_count;
    assign o_overflow     = r_ovf;
    assign o_underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_dp.sv
// tb_sync_fifo_dp: directed self-checking bench for sync_fifo_dp (DEPTH=16, AF=12, AE=4).
// Expected read data comes from a scoreboard queue filled on accepted writes.
module tb_sync_fifo_dp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] data = '0;
    logic        inj = 1'b0;
    logic [31:0] q;
    logic        q_valid, full, empty, af, ae, ovf, unf;
    logic [4:0]  cnt;
`ifdef SYNC_FIFO_DP_PARITY_EN
    logic        perr;
`endif

    int          n_assert = 0;
    int          n_fail = 0;
    int          m_cnt = 0;
    logic [31:0] last_q = '0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    sync_fifo_dp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .AF_LEVEL   (12),
        .AE_LEVEL   (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr_en        (wr_en),
        .i_data         (data),
        .i_rd_en        (rd_en),
        .o_q            (q),
        .o_q_valid      (q_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (af),
        .o_almost_empty (ae),
        .o_word_count   (cnt),
        .o_overflow     (ovf),
        .o_underflow    (unf)
`ifdef SYNC_FIFO_DP_PARITY_EN
        ,
        .i_parity_inj   (inj),
        .o_parity_err   (perr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_q", q, 32'h0);
        chk("rst_qvalid", 32'(q_valid), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_af", 32'(af), 32'h0);
        chk("rst_ae", 32'(ae), 32'h1);
        chk("rst_count", 32'(cnt), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_unf", 32'(unf), 32'h0);
`ifdef SYNC_FIFO_DP_PARITY_EN
        chk("rst_perr", 32'(perr), 32'h0);
`endif
    endtask

    task automatic step(input logic wr, input logic [31:0] d, input logic rd);
        logic        rd_ok, wr_ok;
        logic [32:0] exp_e;
        exp_e = '0;
        @(negedge clk);
        wr_en = wr;
        data  = d;
        rd_en = rd;
        rd_ok = rd && (m_cnt > 0);
        wr_ok = wr && ((m_cnt < 16) || rd_ok);
        if (rd_ok) exp_e = sb.pop_front();
        if (wr_ok) sb.push_back({inj, d});
        m_cnt = m_cnt + ((wr_ok && !rd_ok) ? 1 : 0) - ((rd_ok && !wr_ok) ? 1 : 0);
        @(posedge clk);
        #1;
        if (rd_ok) last_q = exp_e[31:0];
        chk("qvalid", 32'(q_valid), 32'(rd_ok));
        chk("q", q, last_q);
        chk("count", 32'(cnt), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == 16));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("almost_full", 32'(af), 32'(m_cnt >= 12));
        chk("almost_empty", 32'(ae), 32'(m_cnt <= 4));
        chk("overflow", 32'(ovf), 32'(wr && !wr_ok));
        chk("underflow", 32'(unf), 32'(rd && !rd_ok));
`ifdef SYNC_FIFO_DP_PARITY_EN
        chk("parity_err", 32'(perr), 32'(rd_ok && exp_e[32]));
`endif
    endtask

    initial begin
        #12;
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0);
        step(1'b1, 32'h11, 1'b0);
        step(1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);

        step(1'b1, 32'hA5A5A5A5, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 16; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + 32'(i), 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        sb.delete();
        m_cnt = 0;
        last_q = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'hDEADBEEF, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("first_after_reset", q, 32'hDEADBEEF);

`ifdef SYNC_FIFO_DP_PARITY_EN
        inj = 1'b1;
        step(1'b1, 32'h12345678, 1'b0);
        inj = 1'b0;
        step(1'b1, 32'hCAFEF00D, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
